// File: rtl/avalonmem_rx_banked.sv
// Bank-interleaved capture memory: streaming write port plus Avalon-MM read/CSR slave.
// Optional overflow counter at CSR 3 when AVALON_RX_OVERFLOW_CNT_EN is defined.
module avalonmem_rx_banked #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned RD_LATENCY   = 3,
  parameter bit          WRAP_DEFAULT = 1'b0
) (
  input  logic              AVALON_CLK,
  input  logic              AVALON_RESET_N,
  input  logic [ADDR_W:0]   AVALON_ADDRESS,
  input  logic              AVALON_CHIPSELECT,
  input  logic              AVALON_READ,
  input  logic              AVALON_WRITE,
  input  logic [31:0]       AVALON_WRITEDATA,
  output logic [DATA_W-1:0] AVALON_READDATA,
  output logic              AVALON_READDATAVALID,
  input  logic [DATA_W-1:0] MEM_DATA,
  input  logic              MEM_VALID,
  output logic              MEM_READY
);
  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
  localparam int unsigned BSEL_W    = (BANK_BITS == 0) ? 1 : BANK_BITS;
  localparam int unsigned ROW_W     = ADDR_W - BANK_BITS;
  localparam int unsigned ROWS      = 1 << ROW_W;
  localparam int unsigned EXTRA     = RD_LATENCY - 3;
  localparam logic [ADDR_W-1:0] WPTR_MAX  = '1;
  localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_FULL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic                wrapped_q, wrapped_d;
  logic                wrap_q, wrap_d;
  logic                ready_q, ready_d;
  logic                ctrl_wr, clear_wr, rd_acc, accept, arm, full;
  logic [BSEL_W-1:0]   wbank;
  logic [ROW_W-1:0]    wrow;
  logic [31:0]         csr_rd, ovf_rd;
  logic                unused_wdata;

  assign ctrl_wr  = AVALON_CHIPSELECT & AVALON_WRITE & AVALON_ADDRESS[ADDR_W]
                    & (AVALON_ADDRESS[1:0] == 2'd0);
  assign clear_wr = ctrl_wr & AVALON_WRITEDATA[1];
  assign rd_acc   = AVALON_CHIPSELECT & AVALON_READ & ~AVALON_WRITE;
  assign accept   = MEM_VALID & ready_q & ~clear_wr;
  assign arm      = (state_q != ST_IDLE);
  assign full     = (state_q == ST_FULL);
  assign wbank    = BSEL_W'(wptr_q & BANK_MASK);
  assign wrow     = ROW_W'(wptr_q >> BANK_BITS);
  assign MEM_READY    = ready_q;
  assign unused_wdata = ^AVALON_WRITEDATA[31:3];

  // Capture update first, then CTRL write overrides it (CLEAR/disarm win over a same-cycle FULL).
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    wrapped_d = wrapped_q;
    wrap_d    = wrap_q;
    if (accept) begin
      if (wptr_q == WPTR_MAX) begin
        if (wrap_q) begin
          wptr_d    = '0;
          wrapped_d = 1'b1;
        end else begin
          state_d = ST_FULL;
        end
      end else begin
        wptr_d = wptr_q + 1'b1;
      end
    end
    if (ctrl_wr) begin
      wrap_d = AVALON_WRITEDATA[2];
      if (AVALON_WRITEDATA[1]) begin
        wptr_d    = '0;
        wrapped_d = 1'b0;
        if (state_d == ST_FULL) state_d = ST_CAPTURE;
      end
      if (!AVALON_WRITEDATA[0])     state_d = ST_IDLE;
      else if (state_q == ST_IDLE)  state_d = ST_CAPTURE;
    end
    ready_d = (state_d == ST_CAPTURE);
  end

  always_ff @(posedge AVALON_CLK or negedge AVALON_RESET_N) begin
    if (!AVALON_RESET_N) begin
      state_q   <= ST_IDLE;
      wptr_q    <= '0;
      wrapped_q <= 1'b0;
      wrap_q    <= WRAP_DEFAULT;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      wrapped_q <= wrapped_d;
      wrap_q    <= wrap_d;
      ready_q   <= ready_d;
    end
  end

`ifdef AVALON_RX_OVERFLOW_CNT_EN
  logic [15:0] ovf_q;
  always_ff @(posedge AVALON_CLK or negedge AVALON_RESET_N) begin
    if (!AVALON_RESET_N)                                  ovf_q <= '0;
    else if (clear_wr)                                    ovf_q <= '0;
    else if (MEM_VALID & ~ready_q & arm & (ovf_q != '1))  ovf_q <= ovf_q + 16'd1;
  end
  assign ovf_rd = {16'd0, ovf_q};
`else
  assign ovf_rd = '0;
`endif

  // Read pipeline: address reg -> bank RAM output reg -> mux reg -> optional delay.
  logic                s1_vld_q, s2_vld_q, s2_csr_q;
  logic [ADDR_W:0]     s1_addr_q;
  logic [BSEL_W-1:0]   s1_bank, s2_bank_q;
  logic [ROW_W-1:0]    s1_row;
  logic [DATA_W-1:0]   s2_csrdata_q, bank_mux;
  logic [DATA_W-1:0]   mem_q [NUM_BANKS][ROWS];
  logic [DATA_W-1:0]   bank_rd_q [NUM_BANKS];
  logic [EXTRA:0]      pv_q;
  logic [DATA_W-1:0]   pd_q [EXTRA+1];

  assign s1_bank = BSEL_W'(s1_addr_q[ADDR_W-1:0] & BANK_MASK);
  assign s1_row  = ROW_W'(s1_addr_q[ADDR_W-1:0] >> BANK_BITS);

  always_comb begin
    case (s1_addr_q[1:0])
      2'd0:    csr_rd = {29'd0, wrap_q, 1'b0, arm};
      2'd1:    csr_rd = {29'd0, wrapped_q, full, arm};
      2'd2:    csr_rd = 32'(wptr_q);
      default: csr_rd = ovf_rd;
    endcase
  end

  always_comb begin
    bank_mux = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++)
      if (s2_bank_q == BSEL_W'(b)) bank_mux = bank_rd_q[b];
  end

  always_ff @(posedge AVALON_CLK) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (accept && (wbank == BSEL_W'(b))) mem_q[b][wrow] <= MEM_DATA;
      bank_rd_q[b] <= mem_q[b][s1_row];
    end
  end

  always_ff @(posedge AVALON_CLK or negedge AVALON_RESET_N) begin
    if (!AVALON_RESET_N) begin
      s1_vld_q     <= 1'b0;
      s1_addr_q    <= '0;
      s2_vld_q     <= 1'b0;
      s2_csr_q     <= 1'b0;
      s2_bank_q    <= '0;
      s2_csrdata_q <= '0;
      pv_q         <= '0;
      for (int unsigned i = 0; i <= EXTRA; i++) pd_q[i] <= '0;
    end else begin
      s1_vld_q     <= rd_acc;
      s1_addr_q    <= AVALON_ADDRESS;
      s2_vld_q     <= s1_vld_q;
      s2_csr_q     <= s1_addr_q[ADDR_W];
      s2_bank_q    <= s1_bank;
      s2_csrdata_q <= DATA_W'({32'd0, csr_rd});
      pv_q[0]      <= s2_vld_q;
      pd_q[0]      <= s2_csr_q ? s2_csrdata_q : bank_mux;
      for (int unsigned i = 1; i <= EXTRA; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign AVALON_READDATA      = pd_q[EXTRA];
  assign AVALON_READDATAVALID = pv_q[EXTRA];
endmodule

// File: tb/tb_avalonmem_rx_banked.sv
// Bench for avalonmem_rx_banked: table-driven CSR/RAM reads checked through a read scoreboard.
module tb_avalonmem_rx_banked;
  localparam int LAT_A = 3;
  localparam int LAT_B = 5;
`ifdef AVALON_RX_OVERFLOW_CNT_EN
  localparam logic [31:0] OVF_EXP = 32'd8;
`else
  localparam logic [31:0] OVF_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0]  a_addr = '0;  logic a_cs = 0, a_rd = 0, a_wr = 0;
  logic [31:0] a_wdata = '0, a_rdata, a_mdata = '0;
  logic        a_rvalid, a_mvalid = 0, a_mready;
  logic [9:0]  b_addr = '0;  logic b_cs = 0, b_rd = 0, b_wr = 0;
  logic [31:0] b_wdata = '0;
  logic [15:0] b_rdata, b_mdata = '0;
  logic        b_rvalid, b_mvalid = 0, b_mready;

  avalonmem_rx_banked #(.DATA_W(32), .ADDR_W(9), .NUM_BANKS(2), .RD_LATENCY(LAT_A),
                        .WRAP_DEFAULT(0)) u_dut_a (
    .AVALON_CLK(clk), .AVALON_RESET_N(rst_n), .AVALON_ADDRESS(a_addr),
    .AVALON_CHIPSELECT(a_cs), .AVALON_READ(a_rd), .AVALON_WRITE(a_wr),
    .AVALON_WRITEDATA(a_wdata), .AVALON_READDATA(a_rdata),
    .AVALON_READDATAVALID(a_rvalid), .MEM_DATA(a_mdata), .MEM_VALID(a_mvalid),
    .MEM_READY(a_mready));

  avalonmem_rx_banked #(.DATA_W(16), .ADDR_W(9), .NUM_BANKS(4), .RD_LATENCY(LAT_B),
                        .WRAP_DEFAULT(0)) u_dut_b (
    .AVALON_CLK(clk), .AVALON_RESET_N(rst_n), .AVALON_ADDRESS(b_addr),
    .AVALON_CHIPSELECT(b_cs), .AVALON_READ(b_rd), .AVALON_WRITE(b_wr),
    .AVALON_WRITEDATA(b_wdata), .AVALON_READDATA(b_rdata),
    .AVALON_READDATAVALID(b_rvalid), .MEM_DATA(b_mdata), .MEM_VALID(b_mvalid),
    .MEM_READY(b_mready));

  typedef struct { logic [63:0] data; int cyc; } exp_t;
  typedef struct { int ph; logic [9:0] addr; logic [31:0] exp; } vec_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  vec_t vecs[$];
  int n_checks = 0, n_fail = 0, a_nvalid = 0, b_nvalid = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (a_rvalid === 1'b1) begin
      a_nvalid++;
      if (qa.size() == 0) check("a_unexpected_valid", 64'd1, 64'd0);
      else begin
        ea = qa.pop_front();
        check("a_rdata", {32'd0, a_rdata}, ea.data);
        check("a_latency", 64'(cyc - ea.cyc), 64'(LAT_A));
      end
    end
    if (b_rvalid === 1'b1) begin
      b_nvalid++;
      if (qb.size() == 0) check("b_unexpected_valid", 64'd1, 64'd0);
      else begin
        eb = qb.pop_front();
        check("b_rdata", {48'd0, b_rdata}, eb.data);
        check("b_latency", 64'(cyc - eb.cyc), 64'(LAT_B));
      end
    end
  end

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      a_cs = 0; a_rd = 0; a_wr = 0; a_mvalid = 0;
      b_cs = 0; b_rd = 0; b_wr = 0; b_mvalid = 0;
    end
  endtask

  task automatic a_csr_wr(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    a_mvalid = 0; a_cs = 1; a_rd = 0; a_wr = 1; a_addr = {8'h80, r}; a_wdata = d;
  endtask

  task automatic a_read(input logic [9:0] ad, input logic [31:0] e);
    @(negedge clk);
    a_mvalid = 0; a_cs = 1; a_wr = 0; a_rd = 1; a_addr = ad;
    qa.push_back('{data: 64'(e), cyc: cyc});
  endtask

  task automatic b_read(input logic [9:0] ad, input logic [15:0] e);
    @(negedge clk);
    b_mvalid = 0; b_cs = 1; b_wr = 0; b_rd = 1; b_addr = ad;
    qb.push_back('{data: 64'(e), cyc: cyc});
  endtask

  // In stop mode the last accepted beat is index 511; MEM_READY must fall for index 512 onward.
  task automatic a_stream(input int n, input logic [31:0] base, input bit stop_chk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_cs = 0; a_rd = 0; a_wr = 0; a_mvalid = 1; a_mdata = base + 32'(i);
      if (stop_chk && (i == 511 || i == 512 || i == 519))
        check("stop_mready", 64'(a_mready), (i < 512) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", 64'(qa.size() + qb.size()), 64'd0);
    qa.delete(); qb.delete();
  endtask

  task automatic run_vecs(input int ph);
    foreach (vecs[i]) if (vecs[i].ph == ph) a_read(vecs[i].addr, vecs[i].exp);
    quiet(1);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int nv;
    for (int i = 0; i < 4; i++) vecs.push_back('{ph: 0, addr: 10'h200 + 10'(i), exp: 32'h0});
    for (int i = 0; i < 8; i++) vecs.push_back('{ph: 1, addr: 10'(i), exp: 32'h100 + 32'(i)});
    vecs.push_back('{ph: 1, addr: 10'h201, exp: 32'h1});
    vecs.push_back('{ph: 1, addr: 10'h202, exp: 32'h8});
    vecs.push_back('{ph: 1, addr: 10'h200, exp: 32'h1});
    vecs.push_back('{ph: 2, addr: 10'h201, exp: 32'h3});
    vecs.push_back('{ph: 2, addr: 10'h202, exp: 32'h1FF});
    vecs.push_back('{ph: 2, addr: 10'h1FF, exp: 32'h11FF});
    vecs.push_back('{ph: 2, addr: 10'h000, exp: 32'h1000});
    vecs.push_back('{ph: 2, addr: 10'h203, exp: OVF_EXP});
    vecs.push_back('{ph: 3, addr: 10'h201, exp: 32'h5});
    vecs.push_back('{ph: 3, addr: 10'h202, exp: 32'h2});
    vecs.push_back('{ph: 3, addr: 10'h000, exp: 32'h2200});
    vecs.push_back('{ph: 3, addr: 10'h001, exp: 32'h2201});
    vecs.push_back('{ph: 3, addr: 10'h002, exp: 32'h2002});
    vecs.push_back('{ph: 3, addr: 10'h003, exp: 32'h2003});
    vecs.push_back('{ph: 3, addr: 10'h200, exp: 32'h5});
    vecs.push_back('{ph: 4, addr: 10'h202, exp: 32'h0});
    vecs.push_back('{ph: 4, addr: 10'h201, exp: 32'h1});
    vecs.push_back('{ph: 4, addr: 10'h200, exp: 32'h5});
    vecs.push_back('{ph: 4, addr: 10'h005, exp: 32'h2005});
    vecs.push_back('{ph: 4, addr: 10'h002, exp: 32'h3000});
    vecs.push_back('{ph: 4, addr: 10'h004, exp: 32'h3002});
    for (int i = 0; i < 4; i++) vecs.push_back('{ph: 6, addr: 10'h200 + 10'(i), exp: 32'h0});

    repeat (3) @(negedge clk);
    rst_n = 1;
    quiet(2);
    check("rst_mready_a", 64'(a_mready), 64'd0);
    check("rst_rvalid_a", 64'(a_rvalid), 64'd0);
    check("rst_mready_b", 64'(b_mready), 64'd0);
    run_vecs(0);

    // Basic capture and back-to-back readback
    a_csr_wr(2'd0, 32'h1);
    quiet(1);
    check("arm_mready", 64'(a_mready), 64'd1);
    a_stream(8, 32'h100, 1'b0);
    quiet(1);
    run_vecs(1);

    // Stop mode: clear then overrun the buffer
    a_csr_wr(2'd0, 32'h3);
    a_stream(520, 32'h1000, 1'b1);
    quiet(2);
    check("full_mready", 64'(a_mready), 64'd0);
    run_vecs(2);

    // Wrap mode: clear, enable wrap, stream past the end
    a_csr_wr(2'd0, 32'h7);
    a_stream(514, 32'h2000, 1'b0);
    quiet(1);
    run_vecs(3);

    // CLEAR with a concurrent beat at wptr=5, also asserting READ with the write
    a_stream(3, 32'h3000, 1'b0);
    quiet(1);
    nv = a_nvalid;
    @(negedge clk);
    a_mvalid = 1; a_mdata = 32'h3BAD;
    a_cs = 1; a_wr = 1; a_rd = 1; a_addr = 10'h200; a_wdata = 32'h7;
    quiet(6);
    check("rdwr_read_ignored", 64'(a_nvalid), 64'(nv));
    check("clear_mready", 64'(a_mready), 64'd1);
    run_vecs(4);

    // Reset pulse while a read is in flight
    nv = a_nvalid;
    @(negedge clk);
    a_cs = 1; a_rd = 1; a_wr = 0; a_addr = 10'h000;
    @(negedge clk);
    a_cs = 0; a_rd = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    quiet(6);
    check("reset_drops_valid", 64'(a_nvalid), 64'(nv));
    check("reset_mready", 64'(a_mready), 64'd0);
    run_vecs(6);

    // Second configuration: 4 banks, 16-bit data, latency 5
    @(negedge clk);
    b_cs = 1; b_wr = 1; b_rd = 0; b_addr = 10'h200; b_wdata = 32'h1;
    quiet(1);
    check("b_arm_mready", 64'(b_mready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_mvalid = 1; b_mdata = 16'h100 + 16'(i);
    end
    quiet(1);
    for (int i = 0; i < 8; i++) b_read(10'(i), 16'h100 + 16'(i));
    b_read(10'h202, 16'h8);
    b_read(10'h201, 16'h1);
    quiet(1);
    drain();
    check("b_valid_count", 64'(b_nvalid), 64'd10);

    quiet(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/avalonmem_rx_banked.md
Name: avalonmem_rx_banked

Overview:
- Parametrised single-clock capture memory with two ports:
  - a raw streaming write port that fills a bank-interleaved RAM from an auto-incrementing write pointer;
  - an Avalon-MM slave port that reads captured words and a small CSR block.
- Successor of the two-bank dual-pumped receive memory: generalises width, depth and bank count, and adds arm/clear control, a full/wrap policy and fixed-latency reads with READDATAVALID.
- Sits between a datapath producer and the HPS/Avalon interconnect in OCBench.

Parameters:
- DATA_W, 32, data word width (8..64).
- ADDR_W, 9, word-address width; total depth = 2**ADDR_W words.
- NUM_BANKS, 2, interleaved RAM banks; power of 2, 1..8. Bank = wptr[log2(NUM_BANKS)-1:0].
- RD_LATENCY, 3, Avalon read latency in cycles, read accept to READDATAVALID; >= 3.
- WRAP_DEFAULT, 0, reset value of CTRL.WRAP.

Ports:
- AVALON_CLK, in, 1, the single clock for both ports.
- AVALON_RESET_N, in, 1, asynchronous active-low reset.
- AVALON_ADDRESS, in, ADDR_W+1, word address; MSB=0 selects RAM, MSB=1 selects CSR (low 2 bits index).
- AVALON_CHIPSELECT, in, 1, slave select.
- AVALON_READ, in, 1, read strobe; valid only with CHIPSELECT.
- AVALON_WRITE, in, 1, write strobe; CSR only; RAM writes are ignored.
- AVALON_WRITEDATA, in, 32, CSR write data.
- AVALON_READDATA, out, DATA_W, read data.
- AVALON_READDATAVALID, out, 1, read data qualifier.
- MEM_DATA, in, DATA_W, capture data.
- MEM_VALID, in, 1, capture beat present.
- MEM_READY, out, 1, beat accepted when MEM_VALID & MEM_READY.

Behaviour:
- Reset: all outputs 0. wptr=0, ARM=0, FULL=0, WRAPPED=0, WRAP=WRAP_DEFAULT. RAM contents undefined.
- Asserting reset mid-read drops any in-flight READDATAVALID.
- MEM_READY = ARM & ~FULL, registered; it updates the cycle after any state change.
- Accepted beat:
  - written to bank wptr mod NUM_BANKS at row wptr>>log2(NUM_BANKS);
  - then wptr increments.
- Write pointer at 2**ADDR_W-1 on an accepted beat:
  - WRAP=1: wptr goes to 0 and WRAPPED sets (sticky).
  - WRAP=0: FULL sets, MEM_READY drops next cycle, wptr holds at last index.
- States: IDLE (ARM=0) -> CAPTURE (ARM=1, ~FULL) -> FULL (stop mode only).
  - Writing ARM=0 from any state -> IDLE.
  - CLEAR from any state -> wptr=0, FULL=0, WRAPPED=0; ARM is unchanged.
- CSR writes take effect the next cycle. A beat presented on the same cycle as a CLEAR write is dropped and not written.
- CSR map (32-bit; RAM data is zero-extended/truncated to DATA_W on read):
  - 0 CTRL (RW): bit0 ARM, bit1 CLEAR (write-1 self-clearing, reads 0), bit2 WRAP.
  - 1 STATUS (RO): bit0 ARM, bit1 FULL, bit2 WRAPPED.
  - 2 WPTR (RO): wptr, zero-extended.
  - 3 OVF (RO): see Optional Feature.
- Reads:
  - Accepted when CHIPSELECT & READ. No waitrequest; one read per cycle, fully pipelined.
  - Pipeline: address register -> bank RAM registered output -> bank-select mux register. The bank select is delayed in step with the data.
  - RD_LATENCY-3 extra delay stages are added.
  - READDATAVALID pulses exactly RD_LATENCY cycles after accept, one pulse per read. CSR reads use the same latency.
- Read and capture write to the same word in the same cycle: the read returns the old data.
- READ and WRITE asserted together with CHIPSELECT: the write is performed and the read is ignored.

Optional Feature:
- Macro AVALON_RX_OVERFLOW_CNT_EN.
- Defined:
  - 16-bit counter increments each cycle MEM_VALID=1 & MEM_READY=0 while ARM=1, saturating at 16'hFFFF.
  - Cleared by reset and by CLEAR.
  - Readable at CSR 3.
- Undefined: CSR 3 reads 0 and no counter logic is present.

Test Plan:
- Arm (CTRL=0x1), stream 8 beats 0x100..0x107 with NUM_BANKS=2 -> reads of RAM 0..7 return 0x100..0x107; READDATAVALID arrives exactly 3 cycles after each read; back-to-back reads give 8 consecutive valid cycles.
- Stop mode, stream 520 beats -> FULL=1 after beat 512, MEM_READY=0 from the next cycle, WPTR=511, RAM 511=beat 511 value. With the macro defined, OVF=8.
- Wrap mode (CTRL=0x5), stream 514 beats -> WRAPPED=1, WPTR=2, RAM 0/1 hold beats 512/513, RAM 2 holds beat 2.
- CLEAR written while MEM_VALID=1 at wptr=5 -> that beat is not written; WPTR=0, FULL=0, WRAPPED=0, ARM stays 1.
- AVALON_RESET_N low for 1 cycle during a pending read -> no READDATAVALID; MEM_READY=0, STATUS=0, WPTR=0.
- Repeat the first test with NUM_BANKS=4, RD_LATENCY=5, DATA_W=16 -> correct data; valid pulses 5 cycles after each read.
